// File: rtl/test_seq_misr_if.sv
// Stream interface for test_seq_misr: input word handshake and output word handshake.
// Widths follow LANES: 5 bits per input lane, 4 bits per output lane.
interface test_seq_misr_if #(
    parameter int LANES = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [5*LANES-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [4*LANES-1:0]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/test_seq_misr.sv
// LANES-wide 5-in/4-out lane function carried through a DEPTH-stage valid/ready pipeline.
// Defining TEST_SEQ_MISR_EN adds the output MISR signature and transfer counter.
module test_seq_misr #(
    parameter int              LANES = 4,
    parameter int              DEPTH = 2,
    parameter int              SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021,
    parameter int              CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    test_seq_misr_if.slave     bus,
    input  logic               sig_clear,
    output logic [SIG_W-1:0]   sig,
    output logic [CNT_W-1:0]   xfer_cnt
);
    localparam int DW = 4 * LANES;

    logic [DW-1:0]    lane_out;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] ld;
    logic             hole;
    logic [DW-1:0]    data  [DEPTH];
    logic [DEPTH-1:0] src_v;
    logic [DW-1:0]    src_d [DEPTH];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lane_out = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_out[4*i+0] = bus.in_data[5*i+0] ^ bus.in_data[5*i+1];
            lane_out[4*i+1] = (bus.in_data[5*i+2] & bus.in_data[5*i+3]) | bus.in_data[5*i+4];
            lane_out[4*i+2] = ~(bus.in_data[5*i+0] | bus.in_data[5*i+2]);
            lane_out[4*i+3] = bus.in_data[5*i+1] & ~bus.in_data[5*i+4];
        end
    end

    // A stage may load if it or any stage downstream of it has a hole, or the sink takes a word.
    always_comb begin
        hole = 1'b0;
        ld   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            hole  = hole | ~v[k];
            ld[k] = hole | bus.out_ready;
        end
    end

    always_comb begin
        src_v[0] = bus.in_valid;
        src_d[0] = lane_out;
        for (int k = 1; k < DEPTH; k++) begin
            src_v[k] = v[k-1];
            src_d[k] = data[k-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            // NOTE: stage data is reset because out_data must read 0 after reset.
            for (int k = 0; k < DEPTH; k++) data[k] <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (ld[k]) begin
                    v[k] <= src_v[k];
                    if (src_v[k]) data[k] <= src_d[k];
                end
            end
        end
    end

    assign bus.in_ready  = ld[0] & ~rst;
    assign bus.out_valid = v[DEPTH-1] & ~rst;
    assign bus.out_data  = data[DEPTH-1];

`ifdef TEST_SEQ_MISR_EN
    localparam int NCH = (DW + SIG_W - 1) / SIG_W;

    logic [NCH*SIG_W-1:0] padded;
    logic [SIG_W-1:0]     fold;
    logic                 out_xfer;

    assign out_xfer = bus.out_valid & bus.out_ready;

    always_comb begin
        padded         = '0;
        padded[DW-1:0] = bus.out_data;
        fold           = '0;
        for (int i = 0; i < NCH; i++) fold = fold ^ padded[i*SIG_W +: SIG_W];
    end

    // Clear beats a coincident transfer: that word is neither folded nor counted.
    always_ff @(posedge clk) begin
        if (rst || sig_clear) begin
            sig      <= '0;
            xfer_cnt <= '0;
        end else if (out_xfer) begin
            sig      <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end
`else
    logic [SIG_W:0] unused_cfg;
    assign unused_cfg = {sig_clear, POLY};
    assign sig        = '0;
    assign xfer_cnt   = '0;
`endif
endmodule

// File: tb/tb_test_seq_misr.sv
// Bench for test_seq_misr: directed vector table on a LANES=1/DEPTH=2/CNT_W=2 instance,
// then a randomized stream on a LANES=4/DEPTH=3/SIG_W=5 instance against a queue model.
`timescale 1ns/1ps
module tb_test_seq_misr;
`ifdef TEST_SEQ_MISR_EN
    localparam bit MISR_ON = 1'b1;
`else
    localparam bit MISR_ON = 1'b0;
`endif
    localparam int DEPTH_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, clr_a, clr_b;
    logic [15:0] sig_a;
    logic [1:0]  cnt_a;
    logic [4:0]  sig_b;
    logic [15:0] cnt_b;

    test_seq_misr_if #(.LANES(1)) bus_a ();
    test_seq_misr_if #(.LANES(4)) bus_b ();

    test_seq_misr #(.LANES(1), .DEPTH(2), .SIG_W(16), .POLY(16'h1021), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a), .sig_clear(clr_a), .sig(sig_a), .xfer_cnt(cnt_a)
    );

    test_seq_misr #(.LANES(4), .DEPTH(DEPTH_B), .SIG_W(5), .POLY(5'h05), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b), .sig_clear(clr_b), .sig(sig_b), .xfer_cnt(cnt_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        iv;
        logic        ordy;
        logic        clr;
        logic [4:0]  din;
        logic        ir;
        logic        ov;
        logic [3:0]  dout;
        logic [15:0] sig;
        logic [1:0]  cnt;
    } vec_t;

    typedef struct {
        logic [15:0] word;
        int          t;
    } ent_t;

    function automatic logic [15:0] lane_fn(input logic [19:0] x);
        logic [15:0] y;
        logic a, b, c, d, e;
        y = '0;
        for (int i = 0; i < 4; i++) begin
            {e, d, c, b, a} = x[5*i +: 5];
            y[4*i +: 4] = {b & ~e, ~(a | c), (c & d) | e, a ^ b};
        end
        return y;
    endfunction

    function automatic logic [4:0] misr_step(input logic [4:0] s, input logic [15:0] w);
        logic [4:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) f[i % 5] = f[i % 5] ^ w[i];
        return {s[3:0], 1'b0} ^ (s[4] ? 5'h05 : 5'h00) ^ f;
    endfunction

    vec_t tbl [20];
    ent_t q [$];

    initial begin
        logic [4:0]  m_sig;
        logic [15:0] m_cnt;
        logic        do_rst, exp_ir, exp_ov;
        int          cyc;
        ent_t        w;

        // Columns: rst iv ordy clr din | in_ready out_valid out_data sig xfer_cnt
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b00001, 1'b1, 1'b0, 4'h0,    16'h0000, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b0, 4'h0,    16'h0000, 2'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b10110, 1'b1, 1'b1, 4'b0001, 16'h0000, 2'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b1, 4'b0100, 16'h0001, 2'd1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b1, 4'b0011, 16'h0006, 2'd2};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b0, 4'h0,    16'h000F, 2'd3};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00001, 1'b1, 1'b0, 4'h0,    16'h000F, 2'd3};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 4'h0,    16'h000F, 2'd3};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b10110, 1'b0, 1'b1, 4'b0001, 16'h000F, 2'd3};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b10110, 1'b1, 1'b1, 4'b0001, 16'h000F, 2'd3};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 4'b0100, 16'h001F, 2'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 1'b1, 1'b1, 4'b0100, 16'h001F, 2'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b1, 4'b0011, 16'h0000, 2'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b0, 4'h0,    16'h0003, 2'd1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00001, 1'b1, 1'b0, 4'h0,    16'h0003, 2'd1};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 4'h0,    16'h0003, 2'd1};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 4'h0,    16'h0003, 2'd1};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b0, 4'h0,    16'h0000, 2'd0};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b0, 4'h0,    16'h0000, 2'd0};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b0, 4'h0,    16'h0000, 2'd0};

        rst_a = 1'b1; clr_a = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
        rst_b = 1'b1; clr_b = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;

        @(negedge clk);
        check("a reset in_ready", 32'(bus_a.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;

        @(negedge clk);
        check("a post-reset in_ready",  32'(bus_a.in_ready),  32'd1);
        check("a post-reset out_valid", 32'(bus_a.out_valid), 32'd0);
        check("a post-reset out_data",  32'(bus_a.out_data),  32'd0);
        check("a post-reset sig",       32'(sig_a),           32'd0);
        check("a post-reset xfer_cnt",  32'(cnt_a),           32'd0);
        @(posedge clk);
        #1;

        for (int r = 0; r < 20; r++) begin
            rst_a           = tbl[r].rst;
            clr_a           = tbl[r].clr;
            bus_a.in_valid  = tbl[r].iv;
            bus_a.in_data   = tbl[r].din;
            bus_a.out_ready = tbl[r].ordy;
            @(negedge clk);
            check($sformatf("a row%0d in_ready", r),  32'(bus_a.in_ready),  32'(tbl[r].ir));
            check($sformatf("a row%0d out_valid", r), 32'(bus_a.out_valid), 32'(tbl[r].ov));
            if (tbl[r].ov)
                check($sformatf("a row%0d out_data", r), 32'(bus_a.out_data), 32'(tbl[r].dout));
            check($sformatf("a row%0d sig", r),      32'(sig_a), MISR_ON ? 32'(tbl[r].sig) : 32'd0);
            check($sformatf("a row%0d xfer_cnt", r), 32'(cnt_a), MISR_ON ? 32'(tbl[r].cnt) : 32'd0);
            @(posedge clk);
            #1;
        end

        // Randomized stream on the wide instance, modelled as a FIFO of words with accept times.
        rst_b = 1'b0;
        m_sig = '0;
        m_cnt = '0;
        cyc   = 0;
        for (int n = 0; n < 400; n++) begin
            do_rst          = ($urandom_range(0, 99) == 0);
            rst_b           = do_rst;
            clr_b           = ($urandom_range(0, 19) == 0);
            bus_b.in_valid  = ($urandom_range(0, 3) != 0);
            bus_b.in_data   = 20'($urandom);
            bus_b.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            exp_ir = !do_rst && ((q.size() < DEPTH_B) || bus_b.out_ready);
            exp_ov = !do_rst && (q.size() > 0) && ((cyc - q[0].t) >= DEPTH_B);
            check($sformatf("b cyc%0d in_ready", n),  32'(bus_b.in_ready),  32'(exp_ir));
            check($sformatf("b cyc%0d out_valid", n), 32'(bus_b.out_valid), 32'(exp_ov));
            if (exp_ov)
                check($sformatf("b cyc%0d out_data", n), 32'(bus_b.out_data), 32'(q[0].word));
            check($sformatf("b cyc%0d sig", n),      32'(sig_b), MISR_ON ? 32'(m_sig) : 32'd0);
            check($sformatf("b cyc%0d xfer_cnt", n), 32'(cnt_b), MISR_ON ? 32'(m_cnt) : 32'd0);

            if (do_rst) begin
                q.delete();
                m_sig = '0;
                m_cnt = '0;
            end else begin
                if (exp_ov && bus_b.out_ready) begin
                    w = q.pop_front();
                    m_sig = misr_step(m_sig, w.word);
                    m_cnt = m_cnt + 16'd1;
                end
                if (clr_b) begin
                    m_sig = '0;
                    m_cnt = '0;
                end
                if (bus_b.in_valid && exp_ir) q.push_back('{lane_fn(bus_b.in_data), cyc});
            end
            cyc++;
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
